// File: rtl/ff_write_arbiter_if.sv
// Write-request bus between N producer blocks and the shared-register arbiter.
// The master side drives requests and data; the slave side returns grants and register state.
interface ff_write_arbiter_if #(
  parameter int N = 4,
  parameter int W = 4
) ();

  logic [N-1:0]         req;
  logic [N*W-1:0]       wdata;
  logic [N-1:0]         gnt;
  logic [W-1:0]         q;
  logic                 q_valid;
  logic [$clog2(N)-1:0] owner;
  logic [7:0]           wr_count;

  modport master (
    output req,
    output wdata,
    input  gnt,
    input  q,
    input  q_valid,
    input  owner,
    input  wr_count
  );

  modport slave (
    input  req,
    input  wdata,
    output gnt,
    output q,
    output q_valid,
    output owner,
    output wr_count
  );

endinterface : ff_write_arbiter_if

// File: rtl/ff_write_arbiter.sv
// Round-robin write arbiter owning a shared W-bit register: one write per cycle,
// registered one-hot grant to the winner, last winner drops to lowest priority.
module ff_write_arbiter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               reset,
  ff_write_arbiter_if.slave  bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q,      ptr_d;
  logic [N-1:0]  gnt_q,      gnt_d;
  logic [W-1:0]  q_q,        q_d;
  logic          q_valid_q,  q_valid_d;
  logic [PW-1:0] owner_q,    owner_d;
  logic [7:0]    wr_count_q, wr_count_d;

  logic          found;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;

  // Search starts one past the last winner and ends on it, so the last winner is lowest priority.
  // NOTE: every variable gets a default before the loop; a path that skips an assignment infers a latch.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    gnt_d      = '0;
    q_d        = q_q;
    q_valid_d  = q_valid_q;
    owner_d    = owner_q;
    wr_count_d = wr_count_q;
    if (found) begin
      ptr_d      = win;
      gnt_d[win] = 1'b1;
      q_d        = bus.wdata[int'(win)*W +: W];
      q_valid_d  = 1'b1;
      owner_d    = win;
      wr_count_d = wr_count_q + 8'd1;
    end
  end

  // NOTE: non-blocking assignments here so every register samples the pre-edge value of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= PW'(N - 1);
      gnt_q      <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      owner_q    <= '0;
      wr_count_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      owner_q    <= owner_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.q        = q_q;
  assign bus.q_valid  = q_valid_q;
  assign bus.owner    = owner_q;
  assign bus.wr_count = wr_count_q;

  a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(gnt_q));
  a_gnt_owner   : assert property (@(posedge clk) disable iff (reset)
                                   (gnt_q != '0) |-> gnt_q[owner_q]);
  a_valid_holds : assert property (@(posedge clk) disable iff (reset)
                                   q_valid_q |=> q_valid_q);

endmodule : ff_write_arbiter

// File: doc/ff_write_arbiter.md
# ff_write_arbiter

Round-robin write arbiter for a shared W-bit enabled storage register. N requesters each present a write request with data. The block grants exactly one per cycle, performs the write into its internal register, and acknowledges the winner. It sits between several producer blocks and the single shared register, replacing direct drive of the register's `en`/`d` pins.

## Interface

- `N`, default 4: number of requesters; 2..8.
- `W`, default 4: data width of the shared register.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset; sampled on the rising edge of `clk`.
- `req` input N: `req[i]` high requests a write of requester i's data.
- `wdata` input N*W: requester i's data is `wdata[i*W +: W]`.
- `gnt` output N: registered one-hot acknowledge; `gnt[i]` high for exactly one cycle after i's write is committed.
- `q` output W: current contents of the shared register.
- `q_valid` output 1: high once any write has occurred since reset.
- `owner` output clog2(N): index of the requester whose data is in `q`.
- `wr_count` output 8: number of committed writes since reset, modulo 256.

## Operation

- Reset values: `gnt`=0, `q`=0, `q_valid`=0, `owner`=0, `wr_count`=0. The internal priority pointer `ptr` resets to N-1, so requester 0 has highest priority on the first arbitration.
- Each cycle with `reset` low and `req`≠0, the winner is chosen as follows:
  - Search indices (ptr+1) mod N, (ptr+2) mod N, ..., ptr.
  - The first index with `req` high wins.
  - Selection is combinational from the current `req` and `ptr`.
- On the rising edge, for winner k:
  - `q` ← `wdata[k*W +: W]`
  - `owner` ← k
  - `ptr` ← k
  - `q_valid` ← 1
  - `wr_count` ← `wr_count`+1 (wraps 255→0)
  - `gnt` ← one-hot(k)
- If `req`=0: `gnt` ← 0, and `q`, `owner`, `ptr`, `q_valid` and `wr_count` hold.
- Handshake rules:
  - A requester holds `req[i]` and `wdata` slice stable until it sees `gnt[i]`.
  - `req[i]` still high in the cycle where `gnt[i]`=1 counts as a new request and is arbitrated normally. Back-to-back writes from one source are therefore allowed, but the source drops to lowest priority.
- Fairness: with all N requesting continuously, grants rotate 0,1,...,N-1,0,...; no requester waits more than N-1 grants.
- Exactly one write per cycle; there is no queueing. Requests that lose are not remembered and must stay asserted.
- `reset` has priority over everything. Asserting it mid-sequence clears all state on that edge, and any pending requests are dropped without `gnt`.
- Out-of-range data bits and requests on indices ≥N do not exist (`req` is exactly N wide).

## Timing

- Latency: request sampled at edge E, write committed at edge E, and `q` and `gnt` are visible in the cycle after E (1 cycle).
- Throughput: one write per cycle while any `req` is high.
- `gnt` is never multi-hot and is never high two cycles in a row for the same index unless that index is the sole requester.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- **Reset:** hold `reset` 2 cycles with `req`=4'b1111 → all outputs 0, no `gnt`. First cycle after release with `req`=4'b1111 → `gnt`=4'b0001, `q`=`wdata[3:0]`.
- **Single requester:** `req`=4'b0100 with data 4'hA, held 3 cycles → `gnt`=4'b0100 on 3 consecutive cycles, `q`=4'hA, `owner`=2, `wr_count`=3.
- **Full contention:** `req`=4'b1111 for 8 cycles, data i→4'h(i+5) → `gnt` sequence 1,2,4,8,1,2,4,8; `q` follows 5,6,7,8,...
- **Pointer wrap:** last grant to 3, then `req`=4'b1001 → grant 0. Then `req`=4'b1001 → grant 3. `req`=0 for a cycle → `gnt`=0, `q` and `owner` unchanged.
- **Counter wrap:** 256 consecutive writes from requester 1 → `wr_count` returns to 0 and `q_valid` stays 1.
- **Mid-operation reset:** `reset` asserted during a contention burst → next cycle all outputs 0, and the first grant after release goes to requester 0.
